// File: rtl/tc_ram_dma_if.sv
// RAM-side bus of the copy engine: one address, separate load/save strobes,
// four 64-bit write lanes and four 64-bit read lanes. The read lanes are
// combinational from mem_address/mem_load.
interface tc_ram_dma_if;
  logic [15:0] mem_address;
  logic        mem_load;
  logic        mem_save;
  logic [63:0] mem_in0;
  logic [63:0] mem_in1;
  logic [63:0] mem_in2;
  logic [63:0] mem_in3;
  logic [63:0] mem_out0;
  logic [63:0] mem_out1;
  logic [63:0] mem_out2;
  logic [63:0] mem_out3;

  modport master (
    output mem_address, mem_load, mem_save,
    output mem_in0, mem_in1, mem_in2, mem_in3,
    input  mem_out0, mem_out1, mem_out2, mem_out3
  );

  modport slave (
    input  mem_address, mem_load, mem_save,
    input  mem_in0, mem_in1, mem_in2, mem_in3,
    output mem_out0, mem_out1, mem_out2, mem_out3
  );
endinterface

// File: rtl/tc_ram_dma.sv
// RAM-to-RAM word copy engine. Each word takes one READ cycle (data captured
// at the closing edge) and one WRITE cycle. Overlapping copies with the
// destination above the source run descending so no source word is
// overwritten before it is read.
//
// state | meaning
// IDLE  | waiting for start, count holds last result
// READ  | drive src+k with load, capture word
// WRITE | drive dst+k with save, advance k and count
// FIN   | one-cycle done or aborted pulse
module tc_ram_dma #(
  parameter int BIT_WIDTH = 16,
  parameter int UUID      = 0,
  parameter     NAME      = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [15:0] count,
  tc_ram_dma_if.master mem
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

  // Only the low BIT_WIDTH bits of the read lanes form a word; the rest are
  // masked off at capture so the write lanes carry zeros above the word.
  localparam logic [255:0] WORD_MASK = {256{1'b1}} >> (256 - BIT_WIDTH);

  state_t       state, state_nxt;
  logic [15:0]  src_q, dst_q, len_q, k_q;
  logic         desc_q, abort_q;
  logic [255:0] data_q;
  logic [255:0] rd_word;
  logic [15:0]  span;
  logic         dir_desc;
  logic         last_word;

  assign rd_word   = {mem.mem_out3, mem.mem_out2, mem.mem_out1, mem.mem_out0};
  assign span      = dst_addr - src_addr;
  assign dir_desc  = (dst_addr > src_addr) && (span < length);
  assign last_word = ((count + 16'd1) == len_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (length == 16'd0) ? FIN : READ;
      READ:  state_nxt = abort ? FIN : WRITE;
      WRITE: state_nxt = (abort || last_word) ? FIN : READ;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Copy parameters, word offset, captured data and completed-word count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      k_q     <= '0;
      desc_q  <= 1'b0;
      abort_q <= 1'b0;
      data_q  <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src_q   <= src_addr;
          dst_q   <= dst_addr;
          len_q   <= length;
          desc_q  <= dir_desc;
          k_q     <= dir_desc ? (length - 16'd1) : 16'd0;
          abort_q <= 1'b0;
          count   <= '0;
        end
        READ: begin
          data_q <= rd_word & WORD_MASK;
          if (abort) abort_q <= 1'b1;
        end
        WRITE: begin
          count <= count + 16'd1;
          k_q   <= desc_q ? (k_q - 16'd1) : (k_q + 16'd1);
          if (abort) abort_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Status and RAM bus; everything is zero outside READ/WRITE.
  always_comb begin
    busy            = (state == READ) || (state == WRITE);
    done            = (state == FIN) && !abort_q;
    aborted         = (state == FIN) && abort_q;
    mem.mem_address = '0;
    mem.mem_load    = 1'b0;
    mem.mem_save    = 1'b0;
    mem.mem_in0     = '0;
    mem.mem_in1     = '0;
    mem.mem_in2     = '0;
    mem.mem_in3     = '0;
    if (state == READ) begin
      mem.mem_address = src_q + k_q;
      mem.mem_load    = 1'b1;
    end else if (state == WRITE) begin
      mem.mem_address = dst_q + k_q;
      mem.mem_save    = 1'b1;
      {mem.mem_in3, mem.mem_in2, mem.mem_in1, mem.mem_in0} = data_q;
    end
  end

endmodule

// File: tb/tb_tc_ram_dma.sv
// Directed bench for tc_ram_dma: a 16-bit instance and a 256-bit instance,
// each with its own behavioural RAM.
module tb_tc_ram_dma;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- 16-bit instance ----------------
  logic        rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] src_addr = '0, dst_addr = '0, length = '0;
  logic        busy, done, aborted;
  logic [15:0] count;
  tc_ram_dma_if bus ();

  tc_ram_dma #(.BIT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .aborted(aborted), .count(count),
    .mem(bus.master)
  );

  logic [15:0] ram [0:65535];
  logic [15:0] rdq [$];
  int ld_n = 0, sv_n = 0;
  bit both_seen = 1'b0;

  always_comb begin
    bus.mem_out0 = '0;
    bus.mem_out1 = '0;
    bus.mem_out2 = '0;
    bus.mem_out3 = '0;
    if (bus.mem_load) bus.mem_out0 = {48'h0, ram[bus.mem_address]};
  end

  always @(posedge clk) begin
    if (bus.mem_load) begin ld_n++; rdq.push_back(bus.mem_address); end
    if (bus.mem_save) begin sv_n++; ram[bus.mem_address] = bus.mem_in0[15:0]; end
    if (bus.mem_load && bus.mem_save) both_seen = 1'b1;
  end

  // ---------------- 256-bit instance ----------------
  logic        rst_nw = 1'b0, start_w = 1'b0, abort_w = 1'b0;
  logic [15:0] src_w = '0, dst_w = '0, len_w = '0;
  logic        busy_w, done_w, aborted_w;
  logic [15:0] count_w;
  tc_ram_dma_if busw ();

  tc_ram_dma #(.BIT_WIDTH(256)) dutw (
    .clk(clk), .rst_n(rst_nw), .start(start_w), .abort(abort_w),
    .src_addr(src_w), .dst_addr(dst_w), .length(len_w),
    .busy(busy_w), .done(done_w), .aborted(aborted_w), .count(count_w),
    .mem(busw.master)
  );

  logic [255:0] ramw [0:63];
  int sv_w = 0;

  always_comb begin
    {busw.mem_out3, busw.mem_out2, busw.mem_out1, busw.mem_out0} = '0;
    if (busw.mem_load)
      {busw.mem_out3, busw.mem_out2, busw.mem_out1, busw.mem_out0} = ramw[busw.mem_address[5:0]];
  end

  always @(posedge clk) begin
    if (busw.mem_save) begin
      sv_w++;
      ramw[busw.mem_address[5:0]] = {busw.mem_in3, busw.mem_in2, busw.mem_in1, busw.mem_in0};
    end
  end

  // ---------------- helpers ----------------
  task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rdq.delete();
  endtask

  // Returns the cycle (1 = first cycle after acceptance) of done/aborted, 0 on timeout.
  task automatic wait_end(output int cyc, output bit got_done, output bit got_ab);
    cyc = 0; got_done = 1'b0; got_ab = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done || aborted) begin
        cyc = i; got_done = done; got_ab = aborted;
        break;
      end
    end
  endtask

  localparam logic [63:0] L0 = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] L1 = 64'h1111_0000_0000_11FF;
  localparam logic [63:0] L2 = 64'h2222_0000_0000_22FF;
  localparam logic [63:0] L3 = 64'h3333_0000_0000_33FF;

  int cyc;
  bit gd, ga;
  int ld0, sv0, svw0;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
    for (int i = 0; i < 64; i++) ramw[i] = '0;

    // Reset state
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", count, 16'h0);
    chk("rst_addr", bus.mem_address, 16'h0);
    chk("rst_load", bus.mem_load, 1'b0);
    chk("rst_save", bus.mem_save, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; rst_nw = 1'b1;

    // Basic ascending copy of 4 words; a start mid-copy must be ignored
    ram[16'h10] = 16'd1; ram[16'h11] = 16'd2; ram[16'h12] = 16'd3; ram[16'h13] = 16'd4;
    launch(16'h0010, 16'h0040, 16'd4);
    @(negedge clk);
    chk("basic_busy_c1", busy, 1'b1);
    chk("basic_rd_addr_c1", bus.mem_address, 16'h0010);
    @(negedge clk);
    chk("basic_wr_addr_c2", bus.mem_address, 16'h0040);
    chk("basic_wr_data_c2", bus.mem_in0, 64'h1);
    src_addr = 16'h0500; dst_addr = 16'h0600; length = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; gd = 1'b0; ga = 1'b0;
    for (int i = 4; i <= 200; i++) begin
      @(negedge clk);
      if (done || aborted) begin cyc = i; gd = done; ga = aborted; break; end
    end
    chk("basic_done_cycle", cyc, 9);
    chk("basic_done", gd, 1'b1);
    chk("basic_busy_fin", busy, 1'b0);
    chk("basic_count", count, 16'd4);
    chk("basic_ram", {ram[16'h40], ram[16'h41], ram[16'h42], ram[16'h43]}, {16'd1, 16'd2, 16'd3, 16'd4});
    chk("basic_reads", rdq.size(), 4);
    @(negedge clk);
    chk("basic_done_pulse", done, 1'b0);
    repeat (2) @(negedge clk);
    chk("basic_count_hold", count, 16'd4);
    chk("basic_idle_busy", busy, 1'b0);
    chk("basic_idle_addr", bus.mem_address, 16'h0);

    // Overlapping copy, destination above source: descending
    ram[0] = 16'hA; ram[1] = 16'hB; ram[2] = 16'hC; ram[3] = 16'hD; ram[4] = 16'hE;
    launch(16'h0000, 16'h0002, 16'd3);
    wait_end(cyc, gd, ga);
    chk("ovl_done_cycle", cyc, 7);
    chk("ovl_ram", {ram[0], ram[1], ram[2], ram[3], ram[4]},
        {16'hA, 16'hB, 16'hA, 16'hB, 16'hC});
    chk("ovl_nreads", rdq.size(), 3);
    if (rdq.size() == 3)
      chk("ovl_read_order", {rdq[0], rdq[1], rdq[2]}, {16'd2, 16'd1, 16'd0});

    // Source and destination address wrap
    ram[16'hFFFE] = 16'h21; ram[16'hFFFF] = 16'h22; ram[16'h0000] = 16'h23; ram[16'h0001] = 16'h24;
    launch(16'hFFFE, 16'h0100, 16'd4);
    wait_end(cyc, gd, ga);
    chk("wrap_done_cycle", cyc, 9);
    chk("wrap_nreads", rdq.size(), 4);
    if (rdq.size() == 4)
      chk("wrap_read_order", {rdq[0], rdq[1], rdq[2], rdq[3]},
          {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001});
    chk("wrap_ram", {ram[16'h100], ram[16'h101], ram[16'h102], ram[16'h103]},
        {16'h21, 16'h22, 16'h23, 16'h24});

    // Zero-length copy
    ld0 = ld_n; sv0 = sv_n;
    launch(16'h0010, 16'h0080, 16'd0);
    wait_end(cyc, gd, ga);
    chk("len0_done_cycle", cyc, 1);
    chk("len0_done", gd, 1'b1);
    chk("len0_count", count, 16'd0);
    chk("len0_no_load", ld_n - ld0, 0);
    chk("len0_no_save", sv_n - sv0, 0);

    // Abort during the WRITE of word 2 of 5
    for (int i = 0; i < 5; i++) begin
      ram[16'h200 + i] = 16'h50 + 16'(i);
      ram[16'h300 + i] = 16'hDEAD;
    end
    launch(16'h0200, 16'h0300, 16'd5);
    repeat (4) @(negedge clk);
    chk("abort_in_write", bus.mem_save, 1'b1);
    chk("abort_wr_addr", bus.mem_address, 16'h0301);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_pulse", aborted, 1'b1);
    chk("abort_no_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_count", count, 16'd2);
    @(negedge clk);
    chk("abort_pulse_end", aborted, 1'b0);
    chk("abort_ram", {ram[16'h300], ram[16'h301], ram[16'h302]}, {16'h50, 16'h51, 16'hDEAD});
    chk("excl_load_save", both_seen, 1'b0);

    // 256-bit instance: lanes carried through
    ramw[5] = {L3, L2, L1, L0};
    @(negedge clk);
    src_w = 16'd5; dst_w = 16'd9; len_w = 16'd1; start_w = 1'b1;
    @(posedge clk);
    #1 start_w = 1'b0;
    @(negedge clk);
    chk("w_load", busw.mem_load, 1'b1);
    @(negedge clk);
    chk("w_save", busw.mem_save, 1'b1);
    chk("w_lanes", {busw.mem_in3, busw.mem_in2, busw.mem_in1, busw.mem_in0}, {L3, L2, L1, L0});
    @(negedge clk);
    chk("w_done", done_w, 1'b1);
    chk("w_ram", ramw[9], {L3, L2, L1, L0});

    // 256-bit instance: reset during READ
    ramw[32] = {4{64'hCAFE}};
    @(negedge clk);
    src_w = 16'd32; dst_w = 16'd48; len_w = 16'd3; start_w = 1'b1;
    @(posedge clk);
    #1 start_w = 1'b0;
    @(negedge clk);
    chk("wr_busy_read", busw.mem_load, 1'b1);
    svw0 = sv_w;
    #1 rst_nw = 1'b0;
    #1;
    chk("wr_busy_clr", busy_w, 1'b0);
    chk("wr_load_clr", busw.mem_load, 1'b0);
    chk("wr_count_clr", count_w, 16'd0);
    repeat (3) @(negedge clk);
    chk("wr_no_save", sv_w - svw0, 0);
    chk("wr_dst_untouched", ramw[48], 256'h0);
    rst_nw = 1'b1;
    src_w = 16'd5; dst_w = 16'd10; len_w = 16'd1; start_w = 1'b1;
    @(posedge clk);
    #1 start_w = 1'b0;
    chk("wr_first_start", busy_w, 1'b1);
    repeat (3) @(negedge clk);
    chk("wr_copy_after", ramw[10], {L3, L2, L1, L0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tc_ram_dma.md
TC_RAM_DMA -- requirements
Module: tc_ram_dma

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, meaning the RAM word width; legal values are 8, 16, 32, 64, 128 and 256.
REQ-002 SHALL have parameter UUID, default 0, meaning the instance identifier (no functional effect).
REQ-003 SHALL have parameter NAME, default "", meaning the instance label (no functional effect).
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk  in  1  clock, all state on posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  request copy, sampled on posedge while idle.
REQ-007 abort  in  1  cancel the running copy.
REQ-008 src_addr  in  16  first source word address.
REQ-009 dst_addr  in  16  first destination word address.
REQ-010 length  in  16  number of words to copy.
REQ-011 busy  out  1  copy in progress.
REQ-012 done  out  1  one-cycle pulse on normal completion.
REQ-013 aborted  out  1  one-cycle pulse on abort completion.
REQ-014 count  out  16  words written so far in the current or last copy.
REQ-015 mem_address  out  16  RAM address.
REQ-016 mem_load  out  1  RAM read enable.
REQ-017 mem_save  out  1  RAM write enable.
REQ-018 mem_in0..mem_in3  out  64 each  RAM write data lanes.
REQ-019 mem_out0..mem_out3  in  64 each  RAM read data lanes; combinational from mem_address/mem_load.

Function
REQ-020 SHALL implement the FSM states IDLE, READ, WRITE and FIN.
REQ-021 In IDLE with start=1 and length!=0 at a posedge, SHALL latch src_addr, dst_addr and length, clear count, and enter READ.
REQ-022 In IDLE with start=1 and length=0, SHALL enter FIN directly with no RAM access.
REQ-023 SHALL ignore start while not in IDLE.
REQ-024 SHALL select direction at start: descending when dst>src (unsigned) and (dst-src)<length; ascending otherwise, including dst==src.
REQ-025 Ascending: word offset k SHALL take the values 0..length-1; descending: k SHALL take the values length-1..0.
REQ-026 In READ, SHALL drive mem_address=src+k (mod 2^16), mem_load=1 and mem_save=0, capture mem_out lanes [BIT_WIDTH-1:0] into a data register at the posedge, and then enter WRITE.
REQ-027 In WRITE, SHALL drive mem_address=dst+k (mod 2^16), mem_save=1, mem_load=0, with mem_in lanes carrying the captured word and zeros above BIT_WIDTH.
REQ-028 At the posedge ending WRITE, SHALL increment count and advance k, entering READ if words remain and FIN otherwise.
REQ-029 Throughput SHALL be exactly 2 cycles per word; a copy of N words SHALL take 2N+1 cycles from start acceptance to the done cycle, inclusive.
REQ-030 Address arithmetic SHALL wrap modulo 2^16 on both source and destination.
REQ-031 In FIN, SHALL assert done (or aborted if FIN was reached via abort) for one cycle, then return to IDLE.
REQ-032 busy SHALL be 1 in READ and WRITE and 0 in IDLE and FIN.
REQ-033 abort=1 in READ SHALL go to FIN with no save issued.
REQ-034 abort=1 in WRITE SHALL complete that write, increment count, then go to FIN.
REQ-035 abort SHALL be ignored in IDLE and FIN.
REQ-036 Whenever not in READ or WRITE, mem_load, mem_save, mem_address and mem_in SHALL all be 0.
REQ-037 mem_load and mem_save SHALL never be 1 in the same cycle.
REQ-038 count SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-039 rst_n=0 SHALL immediately and asynchronously force IDLE and clear busy, done, aborted, count, mem_*, the data register and the latched addresses to 0.
REQ-040 Reset mid-copy SHALL issue no further save; words already written remain in the RAM.
REQ-041 After rst_n rises, the first start SHALL be accepted on the first posedge.

Verification
REQ-042 BIT_WIDTH=16, RAM[0x10..0x13]=1,2,3,4, start src=0x10 dst=0x40 len=4 -> RAM[0x40..0x43]=1,2,3,4; done in cycle 9 after acceptance; count=4.
REQ-043 Overlap case: RAM[0..4]=A,B,C,D,E, src=0 dst=2 len=3 -> descending copy, RAM[2..4]=A,B,C, with reads observed at 2,1,0.
REQ-044 Wrap case: src=0xFFFE dst=0x0100 len=4 -> reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order.
REQ-045 len=0 -> done one cycle after start, mem_load and mem_save never asserted, count=0.
REQ-046 abort in the WRITE of word 2 of 5 -> aborted pulse, count=2, no done, and dst+2 untouched.
REQ-047 BIT_WIDTH=256, one word 0x..FF in each lane -> all four mem_in lanes match; rst_n low during READ clears busy within the same cycle and issues no save.
